// File: rtl/mem_max_merge_ctrl_pkg.sv
// Shared types and widths for the max-merge sequencer, the Comparator and the memory models.
package mem_max_merge_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_max_merge_ctrl_if.sv
// Control handshake, memory bus and Comparator operand bundle for the max-merge sequencer.
interface mem_max_merge_ctrl_if
    import mem_max_merge_ctrl_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W,
    parameter int LW = LEN_W
);
    logic          start;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          src_rd_en;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_rdata;
    logic          dst_rd_en;
    logic          dst_wr_en;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_rdata;
    logic [DW-1:0] dst_wdata;
    logic [DW-1:0] DOut1;
    logic [DW-1:0] DOut2;
    logic          Sign;
    logic [LW-1:0] wr_count;

    // Sequencer side
    modport master (
        input  start, src_base, dst_base, length, src_rdata, dst_rdata, Sign,
        output busy, done, src_rd_en, src_addr, dst_rd_en, dst_wr_en, dst_addr,
               dst_wdata, DOut1, DOut2, wr_count
    );

    // Top-level control, memories and Comparator side
    modport slave (
        output start, src_base, dst_base, length, src_rdata, dst_rdata, Sign,
        input  busy, done, src_rd_en, src_addr, dst_rd_en, dst_wr_en, dst_addr,
               dst_wdata, DOut1, DOut2, wr_count
    );
endinterface

// File: rtl/mem_max_merge_ctrl_addr_len_counter.sv
// Working source/destination addresses plus the remaining-word down-counter.
// Addresses advance only between words, so after the last word they keep
// pointing at the last location touched.
module mem_max_merge_ctrl_addr_len_counter
    import mem_max_merge_ctrl_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int LW = LEN_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [LW-1:0] length,
    output logic [AW-1:0] src_addr,
    output logic [AW-1:0] dst_addr,
    output logic          last
);
    logic [LW-1:0] remaining;

    // Terminal count: the word being decided is the final one.
    assign last = (remaining == LW'(1));

    // Load on accepted start, step once per decided word; wrap is natural modulo 2^AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_addr  <= '0;
            dst_addr  <= '0;
            remaining <= '0;
        end else if (load) begin
            remaining <= length;
            if (length != '0) begin
                src_addr <= src_base;
                dst_addr <= dst_base;
            end
        end else if (step) begin
            remaining <= remaining - LW'(1);
            if (!last) begin
                src_addr <= src_addr + AW'(1);
                dst_addr <= dst_addr + AW'(1);
            end
        end
    end
endmodule

// File: rtl/mem_max_merge_ctrl.sv
// Element-wise signed max-merge of a source block into a destination block.
//
//   state  | meaning
//   IDLE   | waiting for start; captures bases and length
//   READ   | strobe both memories at the current offset
//   LATCH  | register read data into the Comparator operands
//   DECIDE | write the source word when Sign reports src > dst, then advance
//   DONE   | one-cycle completion pulse
module mem_max_merge_ctrl
    import mem_max_merge_ctrl_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W,
    parameter int LW = LEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_max_merge_ctrl_if.master bus
);
    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          last;
    logic          busy;
    logic          done;
    logic          src_rd_en;
    logic          dst_rd_en;
    logic          dst_wr_en;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dout1_q;
    logic [DW-1:0] dout2_q;
    logic [LW-1:0] wr_count_q;

    assign accept = (state_q == ST_IDLE) && bus.start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a zero-length request goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = (bus.length == '0) ? ST_DONE : ST_READ;
            end
            ST_READ:   state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_DECIDE;
            ST_DECIDE: state_d = last ? ST_DONE : ST_READ;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode; strobes are masked by rst so an aborted DECIDE never writes.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        src_rd_en = (state_q == ST_READ) && !rst;
        dst_rd_en = (state_q == ST_READ) && !rst;
        dst_wr_en = (state_q == ST_DECIDE) && bus.Sign && !rst;
    end

    // Comparator operands captured the cycle after the memory reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout1_q <= '0;
            dout2_q <= '0;
        end else if (state_q == ST_LATCH) begin
            dout1_q <= bus.src_rdata;
            dout2_q <= bus.dst_rdata;
        end
    end

    // Count of words written; cleared only by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst)                                       wr_count_q <= '0;
        else if (accept)                               wr_count_q <= '0;
        else if ((state_q == ST_DECIDE) && bus.Sign)   wr_count_q <= wr_count_q + LW'(1);
    end

    mem_max_merge_ctrl_addr_len_counter #(
        .AW (AW),
        .LW (LW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (state_q == ST_DECIDE),
        .src_base (bus.src_base),
        .dst_base (bus.dst_base),
        .length   (bus.length),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .last     (last)
    );

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.src_rd_en = src_rd_en;
    assign bus.dst_rd_en = dst_rd_en;
    assign bus.dst_wr_en = dst_wr_en;
    assign bus.src_addr  = src_addr;
    assign bus.dst_addr  = dst_addr;
    assign bus.dst_wdata = dout1_q;
    assign bus.DOut1     = dout1_q;
    assign bus.DOut2     = dout2_q;
    assign bus.wr_count  = wr_count_q;
endmodule

// File: tb/tb_mem_max_merge_ctrl.sv
// Directed bench: memory models, signed Comparator model and hand-computed expectations.
module tb_mem_max_merge_ctrl;
    import mem_max_merge_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_max_merge_ctrl_if bus_if ();

    mem_max_merge_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // External signed Comparator
    assign bus_if.Sign = ($signed(bus_if.DOut1) > $signed(bus_if.DOut2));

    logic [7:0] smem [256];
    logic [7:0] dmem [256];
    logic [7:0] wr_log [$];
    logic [7:0] rd_log [$];
    int         done_cnt   = 0;
    int         strobe_cnt = 0;
    int         n_checks   = 0;
    int         n_fail     = 0;

    // Memory models with one-cycle read latency, plus bus activity logs
    always @(posedge clk) begin
        if (bus_if.src_rd_en) begin
            bus_if.src_rdata <= smem[bus_if.src_addr];
            rd_log.push_back(bus_if.src_addr);
        end
        if (bus_if.dst_rd_en) bus_if.dst_rdata <= dmem[bus_if.dst_addr];
        if (bus_if.dst_wr_en) begin
            dmem[bus_if.dst_addr] <= bus_if.dst_wdata;
            wr_log.push_back(bus_if.dst_addr);
        end
        if (bus_if.src_rd_en || bus_if.dst_rd_en || bus_if.dst_wr_en) strobe_cnt++;
        if (bus_if.done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse and count cycles until done (cycle k+1 counts as 1).
    task automatic run_xfer(input logic [7:0] sb, input logic [7:0] db,
                            input logic [8:0] len, output int cycles);
        @(negedge clk);
        bus_if.src_base = sb;
        bus_if.dst_base = db;
        bus_if.length   = len;
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        cycles = 1;
        while (!bus_if.done && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        @(negedge clk);
    endtask

    int cyc;
    int n_wr;
    int done_before;
    int strobe_before;
    logic hit43;

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        bus_if.start     = 1'b0;
        bus_if.src_base  = '0;
        bus_if.dst_base  = '0;
        bus_if.length    = '0;
        bus_if.src_rdata = '0;
        bus_if.dst_rdata = '0;

        // Reset, with start held at the same time: rst must win
        rst = 1'b1;
        bus_if.start  = 1'b1;
        bus_if.length = 9'd4;
        repeat (2) @(negedge clk);
        check("reset_busy", bus_if.busy, 0);
        check("reset_done", bus_if.done, 0);
        check("reset_wr_count", bus_if.wr_count, 0);
        check("reset_src_addr", bus_if.src_addr, 0);
        check("reset_dout1", bus_if.DOut1, 0);
        bus_if.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", bus_if.busy, 0);

        // Basic merge
        smem[8'h00] = 8'h03; smem[8'h01] = 8'h83; smem[8'h02] = 8'h10; smem[8'h03] = 8'h8F;
        dmem[8'h40] = 8'h01; dmem[8'h41] = 8'h80; dmem[8'h42] = 8'h07; dmem[8'h43] = 8'h9F;
        wr_log.delete();
        run_xfer(8'h00, 8'h40, 9'd4, cyc);
        check("basic_latency", cyc, 13);
        check("basic_wr_count", bus_if.wr_count, 3);
        check("basic_d0", dmem[8'h40], 8'h03);
        check("basic_d1", dmem[8'h41], 8'h83);
        check("basic_d2", dmem[8'h42], 8'h10);
        check("basic_d3", dmem[8'h43], 8'h9F);
        hit43 = 1'b0;
        foreach (wr_log[i]) if (wr_log[i] == 8'h43) hit43 = 1'b1;
        check("basic_no_wr_43", hit43, 0);
        check("basic_busy_after", bus_if.busy, 0);

        // Zero length
        strobe_before = strobe_cnt;
        run_xfer(8'h10, 8'h50, 9'd0, cyc);
        check("zero_latency", cyc, 1);
        check("zero_wr_count", bus_if.wr_count, 0);
        check("zero_strobes", strobe_cnt - strobe_before, 0);

        // Address wrap
        smem[8'hFE] = 8'h7F; smem[8'hFF] = 8'h7F; smem[8'h00] = 8'h7F;
        dmem[8'hFF] = 8'h00; dmem[8'h00] = 8'h00; dmem[8'h01] = 8'h00;
        wr_log.delete();
        rd_log.delete();
        run_xfer(8'hFE, 8'hFF, 9'd3, cyc);
        check("wrap_latency", cyc, 10);
        check("wrap_wr_n", wr_log.size(), 3);
        check("wrap_rd_n", rd_log.size(), 3);
        if (wr_log.size() == 3 && rd_log.size() == 3) begin
            check("wrap_wr0", wr_log[0], 8'hFF);
            check("wrap_wr1", wr_log[1], 8'h00);
            check("wrap_wr2", wr_log[2], 8'h01);
            check("wrap_rd0", rd_log[0], 8'hFE);
            check("wrap_rd1", rd_log[1], 8'hFF);
            check("wrap_rd2", rd_log[2], 8'h00);
        end
        check("wrap_dst_addr_hold", bus_if.dst_addr, 8'h01);

        // Equal and signed-extreme operands
        smem[8'h80] = 8'h80; smem[8'h81] = 8'h7F; smem[8'h82] = 8'h55;
        dmem[8'h90] = 8'h7F; dmem[8'h91] = 8'h80; dmem[8'h92] = 8'h55;
        wr_log.delete();
        run_xfer(8'h80, 8'h90, 9'd3, cyc);
        check("ext_wr_count", bus_if.wr_count, 1);
        check("ext_d0", dmem[8'h90], 8'h7F);
        check("ext_d1", dmem[8'h91], 8'h7F);
        check("ext_d2", dmem[8'h92], 8'h55);

        // Reset in a DECIDE cycle with Sign=1
        for (int i = 0; i < 4; i++) begin
            smem[8'h20 + i] = 8'h7F;
            dmem[8'h60 + i] = 8'h00;
        end
        wr_log.delete();
        @(negedge clk);
        bus_if.src_base = 8'h20;
        bus_if.dst_base = 8'h60;
        bus_if.length   = 9'd4;
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        cyc = 0;
        while (!bus_if.dst_wr_en && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_decide", bus_if.dst_wr_en, 1);
        rst = 1'b1;
        #1;
        check("rst_wr_masked", bus_if.dst_wr_en, 0);
        @(negedge clk);
        check("rst_busy", bus_if.busy, 0);
        check("rst_strobes", {bus_if.src_rd_en, bus_if.dst_rd_en, bus_if.dst_wr_en, bus_if.done}, 0);
        check("rst_addrs", {bus_if.src_addr, bus_if.dst_addr}, 0);
        check("rst_operands", {bus_if.DOut1, bus_if.DOut2, bus_if.dst_wdata}, 0);
        check("rst_wr_count", bus_if.wr_count, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_no_writes", wr_log.size(), 0);
        check("rst_dmem_untouched", dmem[8'h60], 8'h00);
        run_xfer(8'h20, 8'h60, 9'd4, cyc);
        check("post_rst_latency", cyc, 13);
        check("post_rst_wr_count", bus_if.wr_count, 4);
        check("post_rst_d3", dmem[8'h63], 8'h7F);

        // Start while busy is ignored
        smem[8'h10] = 8'h05; smem[8'h11] = 8'h06;
        dmem[8'h50] = 8'h01; dmem[8'h51] = 8'h09;
        for (int i = 0; i < 5; i++) begin
            smem[8'h30 + i] = 8'h7F;
            dmem[8'h70 + i] = 8'h00;
        end
        wr_log.delete();
        done_before = done_cnt;
        @(negedge clk);
        bus_if.src_base = 8'h10;
        bus_if.dst_base = 8'h50;
        bus_if.length   = 9'd2;
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        cyc = 1;
        while (!bus_if.done && cyc < 400) begin
            if (cyc == 2) begin
                bus_if.src_base = 8'h30;
                bus_if.dst_base = 8'h70;
                bus_if.length   = 9'd5;
                bus_if.start    = 1'b1;
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus_if.start = 1'b0;
        check("busy_start_latency", cyc, 7);
        repeat (6) @(negedge clk);
        check("busy_start_one_done", done_cnt - done_before, 1);
        check("busy_start_wr_count", bus_if.wr_count, 1);
        check("busy_start_d0", dmem[8'h50], 8'h05);
        check("busy_start_d1", dmem[8'h51], 8'h09);
        check("busy_start_other_dst", dmem[8'h70], 8'h00);
        check("busy_start_idle", bus_if.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_max_merge_ctrl.md
Name: mem_max_merge_ctrl

Overview:
- Sequencer for the memory-to-memory transfer datapath.
- Walks a block of N words, reading source memory and destination memory at matching offsets.
- Presents each pair to the external signed Comparator (DOut1 = source word, DOut2 = destination word) and writes the source word into destination memory only when Comparator Sign reports source > destination.
- Result: an element-wise signed max-merge of source into destination, started by a start/done handshake from the top-level control.

Parameters:
- DATA_W, 8, word width; equals the Comparator operand width.
- ADDR_W, 8, address width of both memories.
- LEN_W, 9, width of the length input; allows up to 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_base  in  ADDR_W  first source address; captured on accepted start.
- dst_base  in  ADDR_W  first destination address; captured on accepted start.
- length  in  LEN_W  number of words; captured on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- src_rd_en  out  1  source memory read strobe.
- src_addr  out  ADDR_W  source memory address.
- src_rdata  in  DATA_W  source read data, valid the cycle after src_rd_en.
- dst_rd_en  out  1  destination memory read strobe.
- dst_wr_en  out  1  destination memory write strobe.
- dst_addr  out  ADDR_W  destination address, shared by read and write.
- dst_rdata  in  DATA_W  destination read data, valid the cycle after dst_rd_en.
- dst_wdata  out  DATA_W  destination write data.
- DOut1  out  DATA_W  Comparator operand, registered source word.
- DOut2  out  DATA_W  Comparator operand, registered destination word.
- Sign  in  1  Comparator result; 1 when DOut1 > DOut2 (two's complement); combinational from DOut1/DOut2.
- wr_count  out  LEN_W  number of words written in the current or most recent transfer.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - busy, done, src_rd_en, dst_rd_en, dst_wr_en, wr_count, DOut1, DOut2, src_addr, dst_addr and dst_wdata all go to 0.
  - Reset mid-transfer aborts immediately; no write is issued in the reset cycle or after it.
- States: IDLE, READ, LATCH, DECIDE, DONE.
- IDLE:
  - start=1 captures src_base, dst_base and length into working address and remaining-count registers, and clears wr_count.
  - If length = 0, next state is DONE; otherwise next state is READ.
- READ (1 cycle):
  - src_rd_en = dst_rd_en = 1.
  - src_addr and dst_addr carry the current addresses.
  - Next state is LATCH.
- LATCH (1 cycle):
  - src_rdata is registered into DOut1 and dst_rdata into DOut2 at the end of the cycle.
  - Next state is DECIDE.
- DECIDE (1 cycle):
  - Sign is valid (the Comparator is combinational on the registered operands).
  - If Sign=1: dst_wr_en=1, dst_addr = current destination address, dst_wdata = DOut1, and wr_count increments.
  - Addresses then increment and the remaining count decrements.
  - Next state is READ if words remain, else DONE.
- DONE (1 cycle):
  - done=1, busy=1.
  - Next state is IDLE.
- Latency: accepted start in cycle k leads to done in cycle k+3N+1 (k+1 when N=0). Throughput is 3 cycles per word.
- Address arithmetic is modulo 2^ADDR_W; a base of 0xFF followed by the next word wraps to 0x00.
- start while busy is ignored; it is neither queued nor allowed to corrupt captured values.
- start and rst asserted together: rst wins.
- Equal operands give Sign=0, so no write occurs.
- Strobes: all are 0 outside the states listed above. Address outputs hold their last value when not strobed.
- wr_count holds its value after done until the next accepted start.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=0, READ=1, LATCH=2, DECIDE=3, DONE=4).
  - DATA_W and ADDR_W defaults shared with the Comparator and the memory models.
- Sub-modules:
  - The Comparator is instantiated beside this block at the top level, not inside it.
  - A small addr_len_counter sub-module (holding the two address incrementers and the remaining counter, with load and step inputs) is natural.
  - The FSM stays in mem_max_merge_ctrl.

Test Plan:
- Basic merge, length=4, src=[03,83,10,8F], dst=[01,80,07,9F] (bases 0x00/0x40):
  - dst becomes [03,83,10,9F].
  - wr_count=3.
  - done exactly 13 cycles after start.
  - No write at dst address 0x43.
- Zero length: start with length=0 gives done 1 cycle later, wr_count=0, and no rd or wr strobes at all.
- Address wrap: src_base=0xFE, dst_base=0xFF, length=3, all src=0x7F, all dst=0x00:
  - Writes go to dst 0xFF, 0x00, 0x01.
  - Reads come from src 0xFE, 0xFF, 0x00.
- Equal and signed-extreme operands: src=[80,7F,55], dst=[7F,80,55]:
  - Only the second word is written (7F > 80 signed).
  - wr_count=1.
- Reset mid-transfer: assert rst in a DECIDE cycle where Sign=1:
  - No dst_wr_en in that or any later cycle.
  - All outputs 0 next cycle.
  - A subsequent start runs normally.
- Start while busy: pulse start with different bases mid-transfer; the transfer completes with the original bases and length, and only one done pulse is seen.
